// File: rtl/parity_pkg.sv
// Shared parity mode definitions for the streaming parity block and the framer.
package parity_pkg;

    typedef enum logic [1:0] {
        PAR_SPACE = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_MARK  = 2'b11
    } par_mode_t;

endpackage

// File: rtl/parity_stream_if.sv
// Beat-side and result-side handshake bundle for parity_stream; slave is the block side.
interface parity_stream_if
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();

    par_mode_t          parity_type;
    logic               check_en;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_par;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_par;
    logic               out_err;
    logic               cnt_clr;
    logic [CNT_W-1:0]   err_cnt;

    modport master (
        output parity_type, check_en, in_valid, in_data, in_par, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_par, out_err, err_cnt
    );

    modport slave (
        input  parity_type, check_en, in_valid, in_data, in_par, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_par, out_err, err_cnt
    );

endinterface

// File: rtl/parity_calc.sv
// Combinational parity bit for one data word under the selected mode.
// Zero latency, no state, no backpressure.
module parity_calc
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  par_mode_t         mode,
    output logic              p
);

    logic x;

    always_comb begin
        x = ^data;
        p = 1'b0;
        case (mode)
            PAR_SPACE: p = 1'b0;
            PAR_ODD:   p = ~x;
            PAR_EVEN:  p = x;
            PAR_MARK:  p = 1'b1;
            default:   p = 1'b0;
        endcase
    end

endmodule

// File: rtl/parity_stream.sv
// Streaming parity generate/check with one registered output stage and saturating error count.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a stalled output blocks input.
module parity_stream
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    parity_stream_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               p;
    logic               err;
    logic               accept;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_par_q;
    logic               out_err_q;
    logic [CNT_W-1:0]   err_cnt_q;

    parity_calc #(.DATA_W(DATA_W)) u_calc (
        .data (bus.in_data),
        .mode (bus.parity_type),
        .p    (p)
    );

    assign err    = bus.check_en & (bus.in_par ^ p);
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_par   = out_par_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_cnt   = err_cnt_q;

    // Payload only loads on accept, so a drained beat leaves stale payload behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data;
            out_par_q   <= p;
            out_err_q   <= err;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            err_cnt_q <= '0;
        end else if (accept && err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench for parity_stream (DATA_W=8, CNT_W=2) with hand-computed expectations.
module tb_parity_stream;
    import parity_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    parity_stream_if #(.DATA_W(8), .CNT_W(2)) bus ();

    parity_stream #(.DATA_W(8), .CNT_W(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_data      = 8'h55;
        bus.in_par       = 1'b0;
        bus.parity_type  = PAR_ODD;
        bus.check_en     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.cnt_clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if ({bus.out_data, bus.out_par, bus.out_err} !== 10'd0) begin errors++; $display("FAIL reset_payload got %h/%b/%b want 00/0/0", bus.out_data, bus.out_par, bus.out_err); end
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_no_early_valid got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin errors++; $display("FAIL first_beat got v=%b d=%h want v=1 d=55", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_par !== 1'b1) begin errors++; $display("FAIL first_beat_par got %b want 1", bus.out_par); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_generate();
        par_mode_t  modes [6] = '{PAR_ODD, PAR_ODD, PAR_EVEN, PAR_EVEN, PAR_SPACE, PAR_MARK};
        logic [7:0] datas [6] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'hFF, 8'h00};
        logic       exps  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.check_en  = 1'b0;
        bus.in_par    = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid    = 1'b1;
            bus.parity_type = modes[i];
            bus.in_data     = datas[i];
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== datas[i]) begin errors++; $display("FAIL gen_beat%0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, datas[i]); end
            checks++; if (bus.out_par !== exps[i] || bus.out_err !== 1'b0) begin errors++; $display("FAIL gen_par%0d got p=%b e=%b want p=%b e=0", i, bus.out_par, bus.out_err, exps[i]); end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_check();
        bus.check_en    = 1'b1;
        bus.parity_type = PAR_EVEN;
        bus.in_data     = 8'h07;
        bus.in_par      = 1'b0;
        bus.in_valid    = 1'b1;
        tick();
        checks++; if (bus.out_err !== 1'b1 || bus.out_par !== 1'b1) begin errors++; $display("FAIL chk_bad got e=%b p=%b want e=1 p=1", bus.out_err, bus.out_par); end
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("FAIL chk_bad_cnt got %0d want 1", bus.err_cnt); end
        bus.in_par = 1'b1;
        tick();
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL chk_good got e=%b want 0", bus.out_err); end
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("FAIL chk_good_cnt got %0d want 1", bus.err_cnt); end
        bus.in_valid = 1'b0;
        bus.check_en = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic       exp_p [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int sent = 0;
        int got  = 0;
        bus.check_en    = 1'b0;
        bus.parity_type = PAR_EVEN;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            bus.out_ready = !(cyc == 2 || cyc == 3);
            bus.in_valid  = (sent < 4);
            bus.in_data   = (sent < 4) ? exp_d[sent] : 8'h00;
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 8'hA1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_c%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=a1", cyc, bus.in_ready, bus.out_valid, bus.out_data); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_data !== exp_d[got] || bus.out_par !== exp_p[got]) begin errors++; $display("FAIL bp_order%0d got d=%h p=%b want d=%h p=%b", got, bus.out_data, bus.out_par, exp_d[got], exp_p[got]); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got %0d beats want 4", got); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.cnt_clr = 1'b1;
        tick();
        checks++; if (bus.err_cnt !== 2'd0) begin errors++; $display("FAIL clr_idle got %0d want 0", bus.err_cnt); end
        bus.cnt_clr     = 1'b0;
        bus.check_en    = 1'b1;
        bus.parity_type = PAR_EVEN;
        bus.in_data     = 8'h07;
        bus.in_par      = 1'b0;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.err_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt%0d got %0d want %0d", i, bus.err_cnt, exp_cnt[i]); end
        end
        bus.cnt_clr = 1'b1;
        tick();
        checks++; if (bus.err_cnt !== 2'd0 || bus.out_err !== 1'b1) begin errors++; $display("FAIL clr_wins got cnt=%0d e=%b want cnt=0 e=1", bus.err_cnt, bus.out_err); end
        bus.cnt_clr  = 1'b0;
        bus.in_valid = 1'b0;
        bus.check_en = 1'b0;
        tick();
    endtask

    task automatic test_mode_change();
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.parity_type = PAR_ODD;
        bus.in_data     = 8'h00;
        tick();
        bus.parity_type = PAR_EVEN;
        bus.in_data     = 8'h03;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_par !== 1'b1) begin errors++; $display("FAIL mode_held got v=%b d=%h p=%b want v=1 d=00 p=1", bus.out_valid, bus.out_data, bus.out_par); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mode_stall_rdy got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'h03 || bus.out_par !== 1'b0) begin errors++; $display("FAIL mode_next got d=%h p=%b want d=03 p=0", bus.out_data, bus.out_par); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready   = 1'b0;
        bus.check_en    = 1'b1;
        bus.parity_type = PAR_EVEN;
        bus.in_data     = 8'h07;
        bus.in_par      = 1'b0;
        bus.in_valid    = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.err_cnt !== 2'd1) begin errors++; $display("FAIL pre_reset got v=%b cnt=%0d want v=1 cnt=1", bus.out_valid, bus.err_cnt); end
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.err_cnt !== 2'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", bus.out_valid, bus.err_cnt, bus.in_ready); end
        tick();
        reset = 1'b0;
        bus.check_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_backpressure();
        test_saturation();
        test_mode_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming parity generator/checker and the parametrised successor of the combinational parity block. Each accepted data beat gets a parity bit computed per a selectable mode, or has its received parity bit checked against that mode. Results pass through one registered output stage with a valid/ready handshake. The block sits between the data source and the serial framer on transmit, and between the deframer and the consumer on receive. A saturating error counter supports link monitoring.

## Interface
- DATA_W, 8, data beat width in bits (>= 1)
- CNT_W, 8, error counter width in bits (>= 1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- parity_type  in  2  mode, sampled with each accepted beat: 00 space, 01 odd, 10 even, 11 mark
- check_en  in  1  sampled with beat: 0 generate, 1 check in_par
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  input data
- in_par  in  1  received parity bit; used only when check_en=1
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  registered copy of in_data
- out_par  out  1  expected parity bit for the beat
- out_err  out  1  1 when check_en=1 and in_par != expected parity
- cnt_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  CNT_W  saturating count of erroring beats

## Operation
- Expected parity p, where x = XOR-reduce(in_data):
  - odd: p = ~x, so data plus p has an odd number of ones
  - even: p = x
  - space: p = 0
  - mark: p = 1
- Generate mode: out_par = p, out_err = 0.
- Check mode: out_par = p, out_err = in_par ^ p.
- Accept condition is in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational from out_ready.
- On accept, the output register loads data, p, err, and out_valid=1.
- While out_valid && !out_ready, all out_* outputs hold stable and in_ready=0.
- If out_valid && out_ready and no accept occurs, out_valid goes to 0 on the next edge. out_data/out_par/out_err keep their old values (don't-care).
- parity_type and check_en apply per beat. Changing them never alters a beat already held in the output register.
- err_cnt:
  - Increments on the edge where a beat with err=1 is loaded.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 on the next edge and wins over a simultaneous increment; that beat is not counted.

## Timing
- Reset values:
  - in_ready=1 (out_valid=0)
  - out_valid=0, out_data=0, out_par=0, out_err=0
  - err_cnt=0
- Latency: a beat accepted at edge N is visible on out_* after edge N, presented in cycle N+1.
- Throughput: 1 beat/cycle when out_ready is held at 1; a simultaneous drain and load leaves out_valid=1.
- Backpressure: one cycle of out_ready=0 with out_valid=1 stalls input exactly one cycle. No beat is lost or duplicated.
- Reset mid-operation: the held beat is discarded; out_valid and err_cnt drop to 0 asynchronously on reset assertion.
- Counter at max with a further error: holds at max; no wrap.

## Structure
- Shared package parity_pkg holds:
  - mode constants PAR_SPACE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_MARK=2'b11
  - function or typedef for the 2-bit parity mode
- Sub-module parity_calc: combinational, parameter DATA_W, inputs data and mode, output p. Reused by the future framer.
- Top parity_stream contains:
  - handshake register stage
  - check XOR
  - saturating counter

## Test plan
- Reset asserted with in_valid=1 -> out_valid=0, err_cnt=0, in_ready=1; after release, first beat appears one cycle after accept.
- DATA_W=8, generate mode:
  - odd, 8'h00 -> out_par=1
  - odd, 8'h01 -> out_par=0
  - even, 8'h01 -> out_par=1
  - even, 8'h03 -> out_par=0
  - space, 8'hFF -> out_par=0
  - mark, 8'h00 -> out_par=1
- Check mode:
  - even, 8'h07 with in_par=0 -> out_err=1, err_cnt 0->1
  - same data with in_par=1 -> out_err=0, err_cnt unchanged
- Backpressure: 4 back-to-back beats 8'hA0..A3 with out_ready low on cycles 2-3 -> outputs stable while stalled, all 4 beats delivered in order, none dropped.
- CNT_W=2: 5 erroring beats -> err_cnt 1,2,3,3,3. Then cnt_clr high in the same cycle as an erroring load -> err_cnt=0.
- Mode change while a beat is stalled in the output register (odd->even) -> held out_par unchanged; next accepted beat uses even.
